// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the bus transaction scheduler.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POP   = 2'd1,
        S_ROUTE = 2'd2,
        S_PUSH  = 2'd3
    } state_e;

    localparam int ID_W      = 8;
    // Widest packet the helper below accepts; callers zero-extend into it.
    localparam int PKT_MAX_W = 64;

    // Destination ID sits in the top ID_W bits of a pkt_w-wide packet.
    function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                                input int                   pkt_w);
        return pkt[pkt_w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_txn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// device that completed a transfer and wraps around.
module rr_arbiter #(
    parameter int drvrs = 4,
    parameter int IDX_W = 2
) (
    input  logic [drvrs-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [drvrs-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan requesters in rotating order and take the first one found.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= drvrs; i++) begin
            cand = IDX_W'((int'(last_grant_i) + i) % drvrs);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/bus_txn_scheduler.sv
// Single-bus packet scheduler: arbitrates among device FIFOs, pops one
// packet, routes it by destination ID (unicast or broadcast) and pushes it
// to the destination FIFOs, stalling on backpressure.
// Optional feature: define BUS_SCHED_STATS_EN to add pkt_cnt/drop_cnt.
module bus_txn_scheduler
    import bus_sched_pkg::*;
#(
    parameter int           bits      = 1,
    parameter int           drvrs     = 4,
    parameter int           pckg_sz   = 16,
    parameter logic [7:0]   broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    input  logic [drvrs-1:0]                full,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic [drvrs-1:0]                grant,
    output logic                            drop
`ifdef BUS_SCHED_STATS_EN
    ,
    output logic [31:0]                     pkt_cnt,
    output logic [31:0]                     drop_cnt
`endif
);

    localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    if (bits != 1) begin : g_bits_chk
        $error("bus_txn_scheduler drives exactly one bus");
    end

    state_e             state_q, state_d;
    logic [drvrs-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [drvrs-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [drvrs-1:0]   route_mask;
    logic [ID_W-1:0]    dst_id;

    rr_arbiter #(
        .drvrs (drvrs),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i        (pndng),
        .last_grant_i (last_q),
        .gnt_o        (arb_gnt),
        .idx_o        (arb_idx)
    );

    // Destination mask of the latched packet; the sender never receives its own packet.
    always_comb begin
        dst_id     = dest_id(PKT_MAX_W'(pkt_q), pckg_sz);
        route_mask = '0;
        if (dst_id == broadcast) begin
            route_mask        = '1;
            route_mask[src_q] = 1'b0;
        end else if ((dst_id < ID_W'(drvrs)) && (dst_id != ID_W'(src_q))) begin
            route_mask[dst_id[IDX_W-1:0]] = 1'b1;
        end
    end

    // Next-state and strobe decode; all strobes come from the current state only.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        src_d   = src_q;
        last_d  = last_q;
        pkt_d   = pkt_q;
        pop     = '0;
        push    = '0;
        D_push  = '0;
        drop    = 1'b0;
        grant   = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (|pndng) begin
                    gnt_d   = arb_gnt;
                    src_d   = arb_idx;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                pop     = gnt_q;
                pkt_d   = D_pop[src_q];
                state_d = S_ROUTE;
            end
            S_ROUTE: begin
                if (route_mask == '0) begin
                    drop    = 1'b1;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if ((route_mask & full) == '0) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                push    = route_mask;
                D_push  = pkt_q;
                last_d  = src_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, grant and latched packet; last_q resets so device 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            src_q   <= '0;
            last_q  <= IDX_W'(drvrs - 1);
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            src_q   <= src_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
        end
    end

`ifdef BUS_SCHED_STATS_EN
    logic [31:0] pkt_cnt_q, drop_cnt_q;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (state_q == S_PUSH) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (drop)              drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_bus_txn_scheduler.sv
// Self-checking bench for bus_txn_scheduler (drvrs=4, pckg_sz=16).
module tb_bus_txn_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         pndng;
    logic [N-1:0][W-1:0]  D_pop;
    logic [N-1:0]         pop;
    logic [N-1:0]         full;
    logic [N-1:0]         push;
    logic [W-1:0]         D_push;
    logic [N-1:0]         grant;
    logic                 drop;
`ifdef BUS_SCHED_STATS_EN
    logic [31:0]          pkt_cnt;
    logic [31:0]          drop_cnt;
`endif

    always #5 clk = ~clk;

    bus_txn_scheduler #(
        .bits      (1),
        .drvrs     (N),
        .pckg_sz   (W),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .full   (full),
        .push   (push),
        .D_push (D_push),
        .grant  (grant),
        .drop   (drop)
`ifdef BUS_SCHED_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    typedef struct {
        int          src;
        logic [15:0] pkt;
        logic [3:0]  mask;
        bit          drp;
    } ev_t;

    int checks = 0;
    int errors = 0;

    ev_t         act_q[$];
    ev_t         exp_q[$];
    logic [15:0] dev_q[N][$];

    int          cyc = 0;
    int          pop_seq = 0, applied_seq = 0, pop_idx = 0, cur_src = 0;
    int          pop_cyc = -1, push_cyc = -1;
    logic [N-1:0] full_prev = '0;
    logic [N-1:0] full_force = '0;
    bit          rand_full = 1'b0;
    int          model_last = N - 1;
    int          exp_pushes = 0, exp_drops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Routing rule from the destination ID alone.
    function automatic logic [3:0] exp_mask(input int src, input logic [15:0] pkt);
        int id;
        id = int'(pkt[15:8]);
        if (id == 255) return 4'hF & ~(4'b0001 << src);
        if (id < N && id != src) return 4'b0001 << id;
        return 4'b0000;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records transfers and checks per-cycle invariants.
    initial forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
            check("pop_onehot0", 64'($onehot0(pop)), 64'd1);
            check("pop_push_excl", 64'((|pop) && (|push)), 64'd0);
            if (push == '0) check("dpush_idle_zero", 64'(D_push), 64'd0);
            if (|pop) begin
                check("grant_at_pop", 64'(grant), 64'(pop));
                for (int i = 0; i < N; i++) if (pop[i]) pop_idx = i;
                cur_src = pop_idx;
                pop_seq++;
                pop_cyc = cyc;
            end
            if (|push) begin
                check("push_vs_full", 64'(push & full_prev), 64'd0);
                act_q.push_back('{src: cur_src, pkt: D_push, mask: push, drp: 1'b0});
                push_cyc = cyc;
            end
            if (drop) act_q.push_back('{src: cur_src, pkt: 16'h0, mask: 4'h0, drp: 1'b1});
        end
        full_prev = full;
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (dev_q[i].size() != 0);
            D_pop[i] = (dev_q[i].size() != 0) ? dev_q[i][0] : 16'h0;
        end
        full = full_force | (rand_full ? 4'($urandom & $urandom) : 4'h0);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (pop_seq != applied_seq) begin
                if (dev_q[pop_idx].size() != 0) void'(dev_q[pop_idx].pop_front());
                applied_seq = pop_seq;
            end
            drive();
        end
    endtask

    task automatic load(input int dev, input logic [15:0] pkt);
        dev_q[dev].push_back(pkt);
    endtask

    // Transaction-level model: drain a snapshot of the device FIFOs round-robin.
    task automatic build_expected();
        logic [15:0] m[N][$];
        int          c, left;
        logic [15:0] p;
        logic [3:0]  mk;
        for (int i = 0; i < N; i++) m[i] = dev_q[i];
        left = 0;
        for (int i = 0; i < N; i++) left += m[i].size();
        while (left > 0) begin
            c = 0;
            for (int k = N; k >= 1; k--) if (m[(model_last + k) % N].size() != 0) c = (model_last + k) % N;
            p  = m[c].pop_front();
            mk = exp_mask(c, p);
            exp_q.push_back('{src: c, pkt: (mk != 0) ? p : 16'h0, mask: mk, drp: (mk == 0)});
            if (mk != 0) begin
                model_last = c;
                exp_pushes++;
            end else begin
                exp_drops++;
            end
            left--;
        end
    endtask

    task automatic run_phase(input string tag, input int ph);
        int t;
        t = 0;
        while (act_q.size() < exp_q.size() && t < 2000) begin
            step(1);
            t++;
        end
        check({tag, "_done"}, 64'(act_q.size() >= exp_q.size()), 64'd1);
        step(3);
        check({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = ph; i < exp_q.size() && i < act_q.size(); i++) begin
            check({tag, "_src"},  64'(act_q[i].src),  64'(exp_q[i].src));
            check({tag, "_drop"}, 64'(act_q[i].drp),  64'(exp_q[i].drp));
            check({tag, "_mask"}, 64'(act_q[i].mask), 64'(exp_q[i].mask));
            check({tag, "_data"}, 64'(act_q[i].pkt),  64'(exp_q[i].pkt));
        end
    endtask

    task automatic wait_pop(input string tag, input int s0);
        int t;
        t = 0;
        while (pop_seq == s0 && t < 20) begin
            step(1);
            t++;
        end
        check({tag, "_pop_seen"}, 64'(pop_seq != s0), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pop"},    64'(pop),    64'd0);
        check({tag, "_push"},   64'(push),   64'd0);
        check({tag, "_grant"},  64'(grant),  64'd0);
        check({tag, "_drop"},   64'(drop),   64'd0);
        check({tag, "_dpush"},  64'(D_push), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int ph, s0, c0, f, n;
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        full  = '0;
        #1 reset = 1'b0;
        #2;
        check_outputs_zero("reset");
`ifdef BUS_SCHED_STATS_EN
        check("reset_pkt_cnt",  64'(pkt_cnt),  64'd0);
        check("reset_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        step(2);
        reset = 1'b1;
        step(2);

        // Fair rotation with every device requesting.
        ph = exp_q.size();
        for (int i = 0; i < N; i++) begin
            load(i, {8'((i + 1) % N), 8'($urandom)});
            load(i, {8'((i + 2) % N), 8'($urandom)});
        end
        build_expected();
        step(1);
        run_phase("rr", ph);
        for (int i = 0; i < 5; i++) begin
            if (ph + i < act_q.size()) check("rr_order", 64'(act_q[ph + i].src), 64'(i % N));
            else check("rr_order_missing", 64'd0, 64'd1);
        end

        // Minimum latency, device 1 -> device 2.
        ph = exp_q.size();
        load(1, 16'h02AB);
        build_expected();
        step(1);
        c0 = cyc;
        run_phase("lat", ph);
        check("lat_pop_cycle",  64'(pop_cyc),  64'(c0 + 1));
        check("lat_push_cycle", 64'(push_cyc), 64'(c0 + 3));

        // Broadcast from device 2.
        ph = exp_q.size();
        load(2, 16'hFF55);
        build_expected();
        step(1);
        run_phase("bcast", ph);
        if (ph < act_q.size()) begin
            check("bcast_mask", 64'(act_q[ph].mask), 64'h0B);
            check("bcast_data", 64'(act_q[ph].pkt),  64'hFF55);
        end else check("bcast_missing", 64'd0, 64'd1);

        // Out-of-range and self-addressed packets are dropped.
        ph = exp_q.size();
        load(0, 16'h0711);
        load(0, 16'h0022);
        build_expected();
        step(1);
        run_phase("drop", ph);
        n = 0;
        for (int i = ph; i < act_q.size(); i++) if (act_q[i].drp) n++;
        check("drop_pulses", 64'(n), 64'd2);
`ifdef BUS_SCHED_STATS_EN
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        check("pkt_cnt",  64'(pkt_cnt),  64'(exp_pushes));
`endif

        // Backpressure on device 3 holds the transfer in routing.
        ph = exp_q.size();
        full_force = 4'b1000;
        load(0, 16'h03C3);
        build_expected();
        s0 = pop_seq;
        step(1);
        wait_pop("stall", s0);
        step(10);
        check("stall_no_push", 64'(act_q.size() - ph), 64'd0);
        full_force = 4'b0000;
        step(1);
        f = cyc;
        run_phase("stall", ph);
        check("stall_release_cycle", 64'(push_cyc), 64'(f + 1));

        // Randomised traffic with random backpressure.
        rand_full = 1'b1;
        for (int r = 0; r < 15; r++) begin
            ph = exp_q.size();
            for (int i = 0; i < N; i++) begin
                int cnt;
                cnt = $urandom_range(0, 3);
                for (int j = 0; j < cnt; j++) begin
                    logic [7:0] id;
                    case ($urandom_range(0, 5))
                        0, 1, 2, 3: id = 8'($urandom_range(0, 3));
                        4:          id = 8'hFF;
                        default:    id = 8'($urandom_range(4, 254));
                    endcase
                    load(i, {id, 8'($urandom)});
                end
            end
            build_expected();
            step(1);
            run_phase("rand", ph);
        end
        rand_full = 1'b0;
        step(1);
`ifdef BUS_SCHED_STATS_EN
        check("rand_pkt_cnt",  64'(pkt_cnt),  64'(exp_pushes));
        check("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif

        // Reset while a packet waits in routing.
        full_force = 4'b1000;
        load(1, 16'h03EE);
        s0 = pop_seq;
        step(1);
        wait_pop("rst", s0);
        step(1);
        #2 reset = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
`ifdef BUS_SCHED_STATS_EN
        check("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        model_last = N - 1;
        exp_pushes = 0;
        exp_drops  = 0;
        full_force = 4'b0000;
        step(3);
        reset = 1'b1;
        ph = act_q.size();
        step(6);
        check("rst_no_stale_push", 64'(act_q.size() - ph), 64'd0);
        ph = exp_q.size();
        load(1, 16'h0233);
        load(0, 16'h0344);
        build_expected();
        step(1);
        run_phase("post_rst", ph);
        if (ph < act_q.size()) check("post_rst_first", 64'(act_q[ph].src), 64'd0);
        else check("post_rst_missing", 64'd0, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
